// File: rtl/demorgan_sweep_ctrl.sv
// Sequencer that sweeps {A,B} over 00..11 into the De Morgan gate unit, checks its 8 outputs and reports results.
// Optional DEMORGAN_SWEEP_FAILMASK_EN adds a sticky per-output fail_mask port.
module demorgan_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       obs,
    output logic             drv_a,
    output logic             drv_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
    ,
    output logic [7:0]       fail_mask
`endif
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             drv_a_nxt, drv_b_nxt, pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [3:0]       fail_vec_nxt;
    logic [7:0]       golden, diff;
    logic             mismatch;
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
    logic [7:0]       fail_mask_nxt;
`endif

    // Expected unit outputs for the vector currently being checked.
    always_comb begin
        golden = {~idx[1], ~idx[0], idx[1] & idx[0], idx[1] | idx[0],
                  ~idx[1] & ~idx[0], ~idx[1] | ~idx[0],
                  ~(idx[1] & idx[0]), ~(idx[1] | idx[0])};
        diff     = obs ^ golden;
        mismatch = |diff;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        drv_a_nxt    = drv_a;
        drv_b_nxt    = drv_b;
        pass_nxt     = pass;
        err_nxt      = err_count;
        fail_vec_nxt = fail_vec;
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
        fail_mask_nxt = fail_mask;
`endif
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = SETTLE;
                    cnt_nxt      = '0;
                    idx_nxt      = 2'd0;
                    drv_a_nxt    = 1'b0;
                    drv_b_nxt    = 1'b0;
                    pass_nxt     = 1'b0;
                    err_nxt      = '0;
                    fail_vec_nxt = 4'd0;
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
                    fail_mask_nxt = 8'd0;
`endif
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_vec_nxt[idx] = 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_nxt = err_count + ERR_W'(1);
                    end
                end
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
                fail_mask_nxt = fail_mask | diff;
`endif
                if (idx != 2'd3) begin
                    idx_nxt                = idx + 2'd1;
                    {drv_a_nxt, drv_b_nxt} = idx + 2'd1;
                    cnt_nxt                = '0;
                    state_nxt              = SETTLE;
                end else begin
                    // Pass is decided here so it already includes the final vector during DONE.
                    pass_nxt  = (err_count == '0) && !mismatch;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 2'd0;
            drv_a     <= 1'b0;
            drv_b     <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'd0;
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
            fail_mask <= 8'd0;
`endif
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            drv_a     <= drv_a_nxt;
            drv_b     <= drv_b_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_vec_nxt;
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
            fail_mask <= fail_mask_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (SETTLE=1/ERR_W=4 and SETTLE=3/ERR_W=1) driven by a faultable gate model.
module tb_demorgan_sweep_ctrl;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1;
    logic        a0, b0, busy0, done0, pass0;
    logic        a1, b1, busy1, done1, pass1;
    logic [3:0]  err0, fv0, fv1;
    logic [0:0]  err1;
    logic [7:0]  obs0, obs1, fm0, fm1;
    logic [31:0] fx0, fx1;   // per-vector XOR fault pattern, byte i applies when {A,B}=i

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] gate_ref(input logic a, input logic b);
        logic [7:0] r;
        r[7] = !a;
        r[6] = !b;
        r[5] = a && b;
        r[4] = a || b;
        r[3] = !a && !b;
        r[2] = !a || !b;
        r[1] = !(a && b);
        r[0] = !(a || b);
        return r;
    endfunction

    function automatic logic [7:0] fbyte(input logic [31:0] fx, input int i);
        return fx[i*8 +: 8];
    endfunction

    assign obs0 = gate_ref(a0, b0) ^ fbyte(fx0, {30'd0, a0, b0});
    assign obs1 = gate_ref(a1, b1) ^ fbyte(fx1, {30'd0, a1, b1});

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(S0), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .obs(obs0),
        .drv_a(a0), .drv_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
        , .fail_mask(fm0)
`endif
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(S1), .ERR_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start1), .obs(obs1),
        .drv_a(a1), .drv_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
        , .fail_mask(fm1)
`endif
    );

`ifndef DEMORGAN_SWEEP_FAILMASK_EN
    assign fm0 = 8'd0;
    assign fm1 = 8'd0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level expectation: a vector fails if any output bit differs; count saturates at 2^errw-1.
    task automatic model(input logic [31:0] fx, input int errw, output logic [3:0] fv,
                         output int err, output logic ps, output logic [7:0] mask);
        int n = 0;
        fv   = 4'd0;
        mask = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (fbyte(fx, i) != 8'd0) begin
                fv[i] = 1'b1;
                n++;
            end
            mask |= fbyte(fx, i);
        end
        err = (n > (1 << errw) - 1) ? (1 << errw) - 1 : n;
        ps  = (n == 0);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    task automatic sweep(input int sel, input logic [31:0] fx, input bit jitter,
                         input logic [3:0] efv, input int eerr, input logic eps, input logic [7:0] emask);
        int  s = (sel == 0) ? S0 : S1;
        int  n = 1;
        bit  seen = 0;
        if (sel == 0) fx0 = fx; else fx1 = fx;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, jitter ? 1'($urandom_range(0, 1)) : 1'b0);
        while (n <= 60) begin
            if ((sel == 0) ? done0 : done1) begin
                seen = 1;
                break;
            end
            chk("busy_in_sweep", (sel == 0) ? busy0 : busy1, 1);
            chk("drv_vector", (sel == 0) ? {a0, b0} : {a1, b1}, (n - 1) / (s + 1));
            @(negedge clk);
            n++;
            set_start(sel, jitter ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        set_start(sel, 1'b0);
        chk("done_seen", seen, 1);
        if (!seen) return;
        chk("done_cycle", n, 4 * (s + 1) + 1);
        chk("busy_at_done", (sel == 0) ? busy0 : busy1, 0);
        chk("fail_vec", (sel == 0) ? fv0 : fv1, efv);
        chk("err_count", (sel == 0) ? err0 : {3'd0, err1}, eerr);
        chk("pass", (sel == 0) ? pass0 : pass1, eps);
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
        chk("fail_mask", (sel == 0) ? fm0 : fm1, emask);
`endif
        @(negedge clk);
        chk("done_pulse_width", (sel == 0) ? done0 : done1, 0);
        chk("drv_hold_11", (sel == 0) ? {a0, b0} : {a1, b1}, 3);
        chk("pass_hold", (sel == 0) ? pass0 : pass1, eps);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] fx;
        bit          jitter;
        logic [3:0]  fv;
        int          err;
        logic        ps;
        logic [7:0]  mask;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [3:0]  mfv;
        int          merr;
        logic        mps;
        logic [7:0]  mmask;
        logic [31:0] rfx;
        int          n;
        bit          seen;

        tbl[0] = '{0, 32'h0000_0000, 0, 4'h0, 0, 1'b1, 8'h00};
        tbl[1] = '{0, 32'h0002_0202, 0, 4'h7, 3, 1'b0, 8'h02};  // nAandB stuck-at-0
        tbl[2] = '{0, 32'hFFFF_FFFF, 0, 4'hF, 4, 1'b0, 8'hFF};
        tbl[3] = '{0, 32'h8000_0000, 0, 4'h8, 1, 1'b0, 8'h80};
        tbl[4] = '{1, 32'hFFFF_FFFF, 1, 4'hF, 1, 1'b0, 8'hFF};  // ERR_W=1 saturates
        tbl[5] = '{1, 32'h0000_0000, 1, 4'h0, 0, 1'b1, 8'h00};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fx0    = 32'd0;
        fx1    = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_drv0", {a0, b0}, 0);
        chk("rst_busy_done0", {busy0, done0}, 0);
        chk("rst_results0", {pass0, err0, fv0}, 0);
        chk("rst_all1", {a1, b1, busy1, done1, pass1, err1, fv1}, 0);
`ifdef DEMORGAN_SWEEP_FAILMASK_EN
        chk("rst_mask", {fm0, fm1}, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].sel, tbl[i].fx, tbl[i].jitter, tbl[i].fv, tbl[i].err, tbl[i].ps, tbl[i].mask);
        end

        // start held high: back-to-back sweeps, results cleared on restart
        fx0 = 32'hFFFF_FFFF;
        @(negedge clk);
        start0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1;
                break;
            end
        end
        chk("held_first_done", seen, 1);
        chk("held_first_err", err0, 4);
        fx0 = 32'd0;
        @(negedge clk);
        chk("held_idle_busy", busy0, 0);
        @(negedge clk);
        chk("held_restart_busy", busy0, 1);
        chk("held_restart_clear", {pass0, err0, fv0}, 0);
        n = 2;
        seen = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done0) begin
                seen = 1;
                break;
            end
        end
        start0 = 1'b0;
        chk("held_second_done", seen, 1);
        chk("held_period", n, 4 * (S0 + 1) + 2);
        chk("held_second_pass", {pass0, err0, fv0}, {1'b1, 4'd0, 4'd0});

        // reset during vector 2 settle abandons the sweep
        repeat (2) @(negedge clk);
        fx0 = 32'hFFFF_FFFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_vector2", {a0, b0, busy0}, 3'b101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_outputs", {a0, b0, busy0, done0, pass0, err0, fv0}, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done0 || busy0) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        sweep(0, 32'd0, 0, 4'h0, 0, 1'b1, 8'h00);

        for (int r = 0; r < 22; r++) begin
            int sel = (r < 16) ? 0 : 1;
            rfx = 32'd0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) rfx[i*8 +: 8] = 8'($urandom);
            end
            model(rfx, (sel == 0) ? 4 : 1, mfv, merr, mps, mmask);
            sweep(sel, rfx, sel == 1, mfv, merr, mps, mmask);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
